debug_frame_tx: RTL and testbench

Transmit-side framer for the MIPS debug link. On a start request it fetches a block of 32-bit debug words (PC, register bank, data memory or pipeline-latch contents, selected by an external mux) and serialises them as a framed, checksummed byte stream into the UART transmitter using its start/done handshake. It is the counterpart of the command and instruction-loading path: that path turns received bytes into words, and this block turns words into transmitted bytes.

---
 rtl/debug_frame_tx.sv | 171 +++++++++++++++++
 tb/tb_debug_frame_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_tx.sv
// Debug-link transmit framer: fetches N debug words and sends them as
// HEADER, count, payload bytes (MSB first) and an XOR checksum over the UART.
module debug_frame_tx #(
    parameter int BITS_SIZE  = 32,
    parameter int SIZE_TRAMA = 8,
    parameter int SEL_BITS   = 8,
    parameter logic [SIZE_TRAMA-1:0] HEADER = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [SEL_BITS-1:0]   i_num_words,
    input  logic                  i_abort,
    input  logic [BITS_SIZE-1:0]  i_word,
    input  logic                  i_tx_done,
    output logic [SEL_BITS-1:0]   o_word_sel,
    output logic                  o_tx_start,
    output logic [SIZE_TRAMA-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NBYTES = BITS_SIZE / SIZE_TRAMA;
    localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_FETCH, S_LATCH, S_DONE
    } state_t;

    // Kind of the byte currently held in r_byte; selects the step after its i_tx_done.
    typedef enum logic [1:0] {
        K_HDR, K_CNT, K_DATA, K_CSUM
    } kind_t;

    state_t                r_state;
    kind_t                 r_kind;
    logic [SIZE_TRAMA-1:0] r_byte;
    logic [SIZE_TRAMA-1:0] r_csum;
    logic [BITS_SIZE-1:0]  r_shift;
    logic [BIW-1:0]        r_byte_idx;
    logic [SEL_BITS:0]     r_word_idx;
    logic [SEL_BITS-1:0]   r_num;
    logic [SEL_BITS-1:0]   r_word_sel;
    logic                  r_tx_start;
    logic [SIZE_TRAMA-1:0] r_tx_data;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_words_left;
    logic                  w_last_byte;
    logic [BITS_SIZE-1:0]  w_next_shift;

    assign w_words_left = (r_word_idx < {1'b0, r_num});
    assign w_last_byte  = (r_byte_idx == BIW'(NBYTES - 1));
    assign w_next_shift = r_shift << SIZE_TRAMA;

    // UART handshake: o_tx_start is a one-cycle request carrying o_tx_data, which
    // stays put until the matching i_tx_done pulse is taken in WAIT.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_kind     <= K_HDR;
            r_byte     <= '0;
            r_csum     <= '0;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_num      <= '0;
            r_word_sel <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            if (i_abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_num      <= i_num_words;
                            r_csum     <= '0;
                            r_byte_idx <= '0;
                            r_word_idx <= '0;
                            r_byte     <= HEADER;
                            r_kind     <= K_HDR;
                            r_busy     <= 1'b1;
                            r_state    <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_byte;
                        if ((r_kind == K_CNT) || (r_kind == K_DATA)) begin
                            r_csum <= r_csum ^ r_byte;
                        end
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (i_tx_done) begin
                            case (r_kind)
                                K_HDR: begin
                                    r_byte  <= SIZE_TRAMA'(r_num);
                                    r_kind  <= K_CNT;
                                    r_state <= S_SEND;
                                end
                                K_CNT: begin
                                    if (w_words_left) begin
                                        r_state <= S_FETCH;
                                    end else begin
                                        r_byte  <= r_csum;
                                        r_kind  <= K_CSUM;
                                        r_state <= S_SEND;
                                    end
                                end
                                K_DATA: begin
                                    if (!w_last_byte) begin
                                        r_shift    <= w_next_shift;
                                        r_byte     <= w_next_shift[BITS_SIZE-1 -: SIZE_TRAMA];
                                        r_byte_idx <= r_byte_idx + 1'b1;
                                        r_state    <= S_SEND;
                                    end else if (w_words_left) begin
                                        r_state <= S_FETCH;
                                    end else begin
                                        r_byte  <= r_csum;
                                        r_kind  <= K_CSUM;
                                        r_state <= S_SEND;
                                    end
                                end
                                default: begin
                                    r_state <= S_DONE;
                                end
                            endcase
                        end
                    end
                    S_FETCH: begin
                        r_word_sel <= r_word_idx[SEL_BITS-1:0];
                        r_state    <= S_LATCH;
                    end
                    S_LATCH: begin
                        r_shift    <= i_word;
                        r_byte     <= i_word[BITS_SIZE-1 -: SIZE_TRAMA];
                        r_byte_idx <= '0;
                        r_word_idx <= r_word_idx + 1'b1;
                        r_kind     <= K_DATA;
                        r_state    <= S_SEND;
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_word_sel = r_word_sel;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: a word memory behind o_word_sel, a UART
// responder driven inline, and an expected-byte queue per frame.
module tb_debug_frame_tx;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_num_words = '0;
    logic        i_abort = 1'b0;
    logic [31:0] i_word;
    logic        i_tx_done = 1'b0;
    logic [7:0]  o_word_sel;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_done;

    logic [31:0] mem [256];
    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_starts = 0;
    int          n_dones = 0;

    assign i_word = mem[o_word_sel];

    debug_frame_tx dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_num_words (i_num_words),
        .i_abort     (i_abort),
        .i_word      (i_word),
        .i_tx_done   (i_tx_done),
        .o_word_sel  (o_word_sel),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_tx_start) n_starts++;
        if (o_done) n_dones++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Runs one frame against exp_q. abort_pos >= 0 aborts right after that byte starts.
    task automatic run_frame(input int n, input int maxd, input bit spur, input int abort_pos);
        int total, s0, d0, gap, w, d;
        logic [7:0] eb;
        bit seen, stable;
        total = exp_q.size();
        s0 = n_starts;
        d0 = n_dones;
        @(negedge i_clk);
        i_num_words = n[7:0];
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("busy_after_start", {31'b0, o_busy}, 1);
        for (int pos = 0; pos < total; pos++) begin
            eb = exp_q.pop_front();
            gap = (pos >= 2 && pos < 2 + 4 * n && ((pos - 2) % 4) == 0) ? 3 : 1;
            seen = 1'b0;
            for (w = 1; w <= 8; w++) begin
                @(negedge i_clk);
                i_tx_done = spur && (gap == 3) && (w == 1);
                i_start = spur;
                if (o_tx_start) begin
                    seen = 1'b1;
                    break;
                end
            end
            i_start = 1'b0;
            i_tx_done = 1'b0;
            check("tx_start_seen", {31'b0, seen}, 1);
            if (!seen) begin
                exp_q.delete();
                return;
            end
            check("tx_gap", w, gap);
            check("tx_data", {24'b0, o_tx_data}, {24'b0, eb});
            if (pos == abort_pos) begin
                i_abort = 1'b1;
                @(negedge i_clk);
                i_abort = 1'b0;
                check("abort_busy", {31'b0, o_busy}, 0);
                check("abort_data_kept", {24'b0, o_tx_data}, {24'b0, eb});
                repeat (2) @(negedge i_clk);
                i_tx_done = 1'b1;
                @(negedge i_clk);
                i_tx_done = 1'b0;
                repeat (3) @(negedge i_clk);
                check("abort_no_done", n_dones - d0, 0);
                check("abort_idle", {31'b0, o_busy}, 0);
                check("abort_start_count", n_starts - s0, pos + 1);
                exp_q.delete();
                return;
            end
            d = $urandom_range(maxd, 0);
            stable = 1'b1;
            repeat (d) begin
                @(negedge i_clk);
                if (o_tx_data !== eb || o_tx_start !== 1'b0) stable = 1'b0;
            end
            check("tx_data_stable", {31'b0, stable}, 1);
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
        end
        @(negedge i_clk);
        check("done_pulse", {31'b0, o_done}, 1);
        check("busy_end", {31'b0, o_busy}, 0);
        @(negedge i_clk);
        check("done_single", {31'b0, o_done}, 0);
        check("start_count", n_starts - s0, total);
        check("done_count", n_dones - d0, 1);
    endtask

    initial begin
        int s0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hBAD0_0000 | i;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_busy", {31'b0, o_busy}, 0);
        check("rst_tx_start", {31'b0, o_tx_start}, 0);
        check("rst_tx_data", {24'b0, o_tx_data}, 0);
        check("rst_word_sel", {24'b0, o_word_sel}, 0);
        check("rst_done", {31'b0, o_done}, 0);
        i_reset = 1'b1;

        // N=0: header, count, checksum only
        exp_q = '{8'hA5, 8'h00, 8'h00};
        run_frame(0, 2, 1'b0, -1);
        check("n0_word_sel", {24'b0, o_word_sel}, 0);

        // N=1
        mem[0] = 32'h1234_5678;
        exp_q = '{8'hA5, 8'h01};
        push_bytes(32'h1234_5678);
        exp_q.push_back(8'h09);
        run_frame(1, 3, 1'b0, -1);
        check("n1_word_sel", {24'b0, o_word_sel}, 0);

        // N=2 with random UART latency
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0001;
        exp_q = '{8'hA5, 8'h02};
        push_bytes(32'hFFFF_FFFF);
        push_bytes(32'h0000_0001);
        exp_q.push_back(8'h03);
        run_frame(2, 20, 1'b0, -1);
        check("n2_word_sel", {24'b0, o_word_sel}, 1);

        // N=3 aborted during word 1, then a complete N=3 frame
        mem[0] = 32'hA1B2_C3D4;
        mem[1] = 32'h1122_3344;
        mem[2] = 32'h5566_7788;
        exp_q = '{8'hA5, 8'h03};
        push_bytes(32'hA1B2_C3D4);
        push_bytes(32'h1122_3344);
        run_frame(3, 2, 1'b0, 7);
        exp_q = '{8'hA5, 8'h03};
        push_bytes(32'hA1B2_C3D4);
        push_bytes(32'h1122_3344);
        push_bytes(32'h5566_7788);
        exp_q.push_back(8'h8F);
        run_frame(3, 2, 1'b0, -1);
        check("n3_word_sel", {24'b0, o_word_sel}, 2);

        // Spurious i_tx_done in IDLE, then a frame with busy starts and LATCH tx_done
        s0 = n_starts;
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        repeat (2) @(negedge i_clk);
        check("idle_txdone_busy", {31'b0, o_busy}, 0);
        check("idle_txdone_starts", n_starts - s0, 0);
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0001;
        exp_q = '{8'hA5, 8'h02};
        push_bytes(32'hFFFF_FFFF);
        push_bytes(32'h0000_0001);
        exp_q.push_back(8'h03);
        run_frame(2, 4, 1'b1, -1);

        // Asynchronous reset mid-frame, between clock edges
        @(negedge i_clk);
        i_num_words = 8'd1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        check("pre_reset_busy", {31'b0, o_busy}, 1);
        check("pre_reset_data", {24'b0, o_tx_data}, 32'hA5);
        #2 i_reset = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, o_busy}, 0);
        check("async_rst_tx_start", {31'b0, o_tx_start}, 0);
        check("async_rst_tx_data", {24'b0, o_tx_data}, 0);
        check("async_rst_word_sel", {24'b0, o_word_sel}, 0);
        check("async_rst_done", {31'b0, o_done}, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        mem[0] = 32'hCAFE_F00D;
        exp_q = '{8'hA5, 8'h01};
        push_bytes(32'hCAFE_F00D);
        exp_q.push_back(8'hC8);
        run_frame(1, 3, 1'b0, -1);

        repeat (2) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
